imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction loader that sits directly upstream of `mips_core` and the instruction memory. It receives a program as a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words into the instruction memory write port and holds the core in reset until the whole image has arrived and its checksum has been verified.

## Interface
Parameters:
- `ADDR_W`, 6: instruction memory word-address width; matches the core's `iaddr`.
- `DEPTH`, 64: maximum image size in words; fixed at 2**ADDR_W.

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `rx_data`, in, 8: incoming byte.
- `rx_valid`, in, 1: `rx_data` is valid.
- `rx_ready`, out, 1: loader can accept a byte. A byte transfers on a rising edge where `rx_valid && rx_ready`.
- `wr_en`, out, 1: instruction memory write strobe; one cycle per word.
- `wr_addr`, out, ADDR_W: instruction memory word address.
- `wr_data`, out, 32: instruction word.
- `core_rst`, out, 1: active-high reset to `mips_core`.
- `done`, out, 1: image loaded and verified; core running.
- `err`, out, 1: load failed; core held in reset.

## Operation
- Frame format: one header byte N, then 4·N program bytes, then one checksum byte. Each word's bytes arrive MSB first: byte 0 goes to [31:24], byte 3 to [7:0].
- Header handling:
  - N=0 means DEPTH words.
  - N>DEPTH is a header error.
- Checksum rule: the checksum byte must equal the XOR of the header byte and all program bytes.
- States are one-hot and registered.
- HEADER:
  - `rx_ready`=1.
  - On transfer: latch the word count, seed the running XOR with the byte, and clear the word index.
  - If N>DEPTH go to ERROR, otherwise go to LOAD.
- LOAD:
  - `rx_ready`=1.
  - Shift bytes into a 32-bit assembly register with a 2-bit byte counter. Fold each byte into the running XOR.
  - When the 4th byte of a word transfers, the next cycle has `wr_en`=1, `wr_data`=assembled word and `wr_addr`=word index. The word index then increments.
  - After the last word's 4th byte, go to CHECK.
- CHECK:
  - `rx_ready`=1.
  - On transfer: if the byte equals the running XOR, go to RUN; otherwise go to ERROR.
- RUN: `rx_ready`=0, `core_rst`=0, `done`=1. Terminal until reset.
- ERROR: `rx_ready`=0, `core_rst`=1, `err`=1. Terminal until reset.
- Output decode:
  - `core_rst` is 1 in every state except RUN.
  - `done` and `err` are never both 1.
- Bytes presented with `rx_ready`=0, or while `rst` is low, are ignored.
- `wr_en` is never asserted outside the cycle following a completed word.
- Word index never exceeds DEPTH-1; no wrap-around write occurs.

## Timing
- Reset values (asynchronous on `rst` low): state HEADER, `rx_ready`=1 once `rst` is high, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `core_rst`=1, `done`=0, `err`=0.
- Internal reset values: counters and running XOR cleared.
- Reset mid-load:
  - All outputs return to reset values immediately and the frame restarts at HEADER.
  - Words already written remain in memory and are overwritten by the next load.
- Write latency: `wr_en` is high for exactly the one cycle after the edge that accepts byte 3 of a word. Gaps in `rx_valid` only stretch the load, never change the write data.
- Back-to-back transfers sustain 1 byte/cycle. The minimum frame is 4·N+2 cycles.
- Release timing:
  - The final word's write completes on the same edge that the checksum byte can earliest be accepted.
  - `core_rst`, `done` and `err` change combinationally from the state flops on the edge that accepts the checksum byte.
  - The core therefore sees its first fetch after the final write.
- Header error: ERROR is entered on the header-accept edge, so `err`=1 in the following cycle.

## Test plan
- Header 0x02, bytes 20 08 00 05 20 09 00 0A, checksum 0x0C, back-to-back -> writes addr 0 = 0x20080005 and addr 1 = 0x2009000A. Then `done`=1, `core_rst`=0, `rx_ready`=0.
- Same frame with checksum 0x0D -> both writes occur, then `err`=1, `core_rst`=1, `done`=0, `rx_ready`=0. Further bytes are ignored.
- Header 0x41 -> `err`=1 the next cycle, no `wr_en` ever, `core_rst`=1.
- Header 0x00 with 256 bytes of incrementing words and correct checksum -> exactly 64 writes, the last at `wr_addr`=63, then `done`=1.
- Frame of test 1 with `rx_valid` asserted only every third cycle -> identical writes and result. `wr_en` is high exactly twice, each time for one cycle.
- Assert `rst` low after 6 bytes of frame 1 -> outputs return to reset values without waiting for a clock edge. Resend full frame 1 -> addr 0 rewritten to 0x20080005, then `done`=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake plus instruction-memory write port of the boot loader.
// The slave side is the loader; the master side is the byte source / memory model.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction loader: framed byte stream -> big-endian words in imem,
// holding the core in reset until the image checksum verifies.
module imem_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  imem_loader_if.slave    bus,
  output logic            core_rst,
  output logic            done,
  output logic            err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ASM_W  = WORD_W - BYTE_W;

  typedef enum logic [4:0] {
    S_HDR  = 5'b00001,
    S_LOAD = 5'b00010,
    S_CHK  = 5'b00100,
    S_RUN  = 5'b01000,
    S_ERR  = 5'b10000
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [ASM_W-1:0]    asm_q;
  logic [1:0]          byte_cnt;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   last_idx;
  logic [BYTE_W-1:0]   xor_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [WORD_W-1:0]   wr_data_q;

  logic                in_hdr;
  logic                in_load;
  logic                in_chk;
  logic                xfer;
  logic                hdr_too_big;
  logic [ADDR_W-1:0]   hdr_last;
  logic                word_done;
  logic                last_word;

  assign in_hdr  = (state == S_HDR);
  assign in_load = (state == S_LOAD);
  assign in_chk  = (state == S_CHK);

  assign bus.rx_ready = rst & (in_hdr | in_load | in_chk);
  assign xfer         = bus.rx_valid & bus.rx_ready;

  // Header byte 0 encodes a full image of DEPTH words
  assign hdr_too_big = 32'(bus.rx_data) > DEPTH;
  assign hdr_last    = (bus.rx_data == '0) ? ADDR_W'(DEPTH - 1)
                                           : ADDR_W'(32'(bus.rx_data) - 32'd1);

  assign word_done = in_load & xfer & (byte_cnt == 2'd3);
  assign last_word = word_done & (idx == last_idx);

  // Status decode straight from the one-hot state flops
  assign core_rst = (state != S_RUN);
  assign done     = (state == S_RUN);
  assign err      = (state == S_ERR);

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_HDR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_HDR: begin
        if (xfer) begin
          state_nxt = hdr_too_big ? S_ERR : S_LOAD;
        end
      end
      S_LOAD: begin
        if (last_word) begin
          state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (xfer) begin
          state_nxt = (bus.rx_data == xor_q) ? S_RUN : S_ERR;
        end
      end
      S_RUN: state_nxt = S_RUN;
      S_ERR: state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // Word assembly, running XOR and the registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q     <= '0;
      byte_cnt  <= '0;
      idx       <= '0;
      last_idx  <= '0;
      xor_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (in_hdr && xfer) begin
        last_idx <= hdr_last;
        xor_q    <= bus.rx_data;
        idx      <= '0;
        byte_cnt <= '0;
      end
      if (in_load && xfer) begin
        xor_q    <= xor_q ^ bus.rx_data;
        byte_cnt <= byte_cnt + 2'd1;
        asm_q    <= {asm_q[ASM_W-BYTE_W-1:0], bus.rx_data};
      end
      if (word_done) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= idx;
        wr_data_q <= {asm_q, bus.rx_data};
        if (!last_word) begin
          idx <= idx + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, header error, full image,
// throttled input and mid-load reset.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 6;

  logic clk = 1'b0;
  logic rst;
  logic core_rst;
  logic done;
  logic err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]        pbuf [256];
  logic [7:0]        f1   [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
  logic [ADDR_W-1:0] wa [$];
  logic [31:0]       wd [$];

  // Log every cycle with wr_en high
  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa.push_back(bus.wr_addr);
      wd.push_back(bus.wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic load_f1();
    for (int i = 0; i < 8; i++) pbuf[i] = f1[i];
  endtask

  // Called at a negedge; returns at the next negedge after one transfer edge
  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    send_byte(b);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input int nb, input logic [7:0] ck, input int gap);
    send_gap(hdr, gap);
    for (int i = 0; i < nb; i++) send_gap(pbuf[i], gap);
    send_gap(ck, gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_log();
  endtask

  task automatic check_f1_writes(input string tag);
    check({tag, "_nwr"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check({tag, "_a0"}, 32'(wa[0]), 32'd0);
      check({tag, "_d0"}, wd[0], 32'h2008_0005);
      check({tag, "_a1"}, 32'(wa[1]), 32'd1);
      check({tag, "_d1"}, wd[1], 32'h2009_000A);
    end
  endtask

  initial begin
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state
    #3;
    check("rst_wr_en",    32'(bus.wr_en),   32'd0);
    check("rst_wr_addr",  32'(bus.wr_addr), 32'd0);
    check("rst_wr_data",  bus.wr_data,      32'd0);
    check("rst_core_rst", 32'(core_rst),    32'd1);
    check("rst_done",     32'(done),        32'd0);
    check("rst_err",      32'(err),         32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);

    // Good two-word frame, back to back
    clear_log();
    load_f1();
    send_frame(8'h02, 8, 8'h0C, 0);
    check_f1_writes("t1");
    check("t1_done",     32'(done),         32'd1);
    check("t1_core_rst", 32'(core_rst),     32'd0);
    check("t1_err",      32'(err),          32'd0);
    check("t1_rx_ready", 32'(bus.rx_ready), 32'd0);

    // Bad checksum
    do_reset();
    load_f1();
    send_frame(8'h02, 8, 8'h0D, 0);
    check_f1_writes("t2");
    check("t2_err",      32'(err),          32'd1);
    check("t2_core_rst", 32'(core_rst),     32'd1);
    check("t2_done",     32'(done),         32'd0);
    check("t2_rx_ready", 32'(bus.rx_ready), 32'd0);
    send_byte(8'h0C);
    send_byte(8'h55);
    check("t2_ign_err",  32'(err),          32'd1);
    check("t2_ign_done", 32'(done),         32'd0);
    check("t2_ign_nwr",  32'(wa.size()),    32'd2);

    // Header above DEPTH
    do_reset();
    send_byte(8'h41);
    check("t3_err",      32'(err),      32'd1);
    check("t3_core_rst", 32'(core_rst), 32'd1);
    check("t3_done",     32'(done),     32'd0);
    for (int i = 0; i < 6; i++) send_byte(8'(i));
    check("t3_nwr",      32'(wa.size()), 32'd0);
    check("t3_err_hold", 32'(err),       32'd1);

    // Full 64-word image via header 0; XOR of bytes 0..255 is 0
    do_reset();
    for (int i = 0; i < 256; i++) pbuf[i] = 8'(i);
    send_frame(8'h00, 256, 8'h00, 0);
    check("t4_nwr", 32'(wa.size()), 32'd64);
    if (wa.size() == 64) begin
      check("t4_a0",  32'(wa[0]),  32'd0);
      check("t4_d0",  wd[0],       32'h0001_0203);
      check("t4_a63", 32'(wa[63]), 32'd63);
      check("t4_d63", wd[63],      32'hFCFD_FEFF);
    end
    check("t4_done",     32'(done),     32'd1);
    check("t4_core_rst", 32'(core_rst), 32'd0);

    // rx_valid every third cycle
    do_reset();
    load_f1();
    send_frame(8'h02, 8, 8'h0C, 2);
    check_f1_writes("t5");
    check("t5_done", 32'(done), 32'd1);
    check("t5_err",  32'(err),  32'd0);

    // Reset after six bytes, then reload
    do_reset();
    load_f1();
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(pbuf[i]);
    check("t6_lat_wr_en",   32'(bus.wr_en),   32'd1);
    check("t6_lat_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("t6_lat_wr_data", bus.wr_data,      32'h2008_0005);
    send_byte(pbuf[4]);
    check("t6_wr_en_off",   32'(bus.wr_en),   32'd0);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_wr_en",    32'(bus.wr_en),   32'd0);
    check("t6_rst_wr_addr",  32'(bus.wr_addr), 32'd0);
    check("t6_rst_wr_data",  bus.wr_data,      32'd0);
    check("t6_rst_core_rst", 32'(core_rst),    32'd1);
    check("t6_rst_done",     32'(done),        32'd0);
    check("t6_rst_err",      32'(err),         32'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_log();
    send_frame(8'h02, 8, 8'h0C, 0);
    check_f1_writes("t6");
    check("t6_done", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
